// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_if : fetch, data and memory-side bus bundle of mem_arbiter.
// Revision       : 1.0
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  logic              stall_o;

  // Arbiter view
  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ready_i,
    output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );

  // CPU + memory view
  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_rdata_i, mem_ready_i,
    input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : shares one single-ported memory between fetch and data ports.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DM_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input wire           clk_i,
  input wire           rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_ACC = 2'd1,
    S_DM_ACC = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              err_q, err_d;

  logic              grant_dm;
  logic              grant_if;

  // Data has priority unless it has starved a waiting fetch long enough.
  always_comb begin
    grant_dm = bus.dm_req_i & (~bus.if_req_i | (streak_q != STREAK_MAX));
    grant_if = bus.if_req_i & ~grant_dm;
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          state_d    = S_DM_ACC;
          mem_req_d  = 1'b1;
          mem_we_d   = bus.dm_we_i;
          mem_addr_d = bus.dm_addr_i;
          if (bus.dm_we_i) begin
            mem_wdata_d = bus.dm_wdata_i;
          end
          if (!bus.if_req_i) begin
            streak_d = 4'd0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (grant_if) begin
          state_d    = S_IF_ACC;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr_i;
          streak_d   = 4'd0;
        end
      end

      S_IF_ACC, S_DM_ACC: begin
        if (bus.mem_ready_i) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == S_IF_ACC) begin
            if_rdata_d = bus.mem_rdata_i;
            if_ack_d   = 1'b1;
          end else begin
            // A store returns no data; keep the last load value visible.
            if (!mem_we_q) begin
              dm_rdata_d = bus.mem_rdata_i;
            end
            dm_ack_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          tmo_d     = tmo_q + 8'd1;
          if (state_q == S_IF_ACC) begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
          end else begin
            dm_rdata_d = '0;
            dm_ack_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_RESP: begin
        tmo_d   = 8'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      streak_q    <= 4'd0;
      tmo_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
  assign bus.err_o       = err_q;

  // Stall drops in the ack cycle so the pipeline advances on completion.
  assign bus.stall_o = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed and randomized self-checking bench for mem_arbiter.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_addr_i   = '0;
    bus.dm_wdata_i  = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ready_i = 1'b0;
  endtask

  // Serves the memory side until an ack appears; returns at the ack cycle.
  task automatic do_access(input int waits, input logic [31:0] rd, output int reqc,
                           output logic [31:0] a, output logic we, output logic [31:0] wd,
                           output logic ia, output logic da, output logic er);
    reqc = 0; a = '0; we = 1'b0; wd = '0; ia = 1'b0; da = 1'b0; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.if_ack_o || bus.dm_ack_o) begin
        ia = bus.if_ack_o; da = bus.dm_ack_o; er = bus.err_o;
        break;
      end
      if (bus.mem_req_o) begin
        if (reqc == 0) begin
          a = bus.mem_addr_o; we = bus.mem_we_o; wd = bus.mem_wdata_o;
        end
        reqc++;
      end
      bus.mem_ready_i = bus.mem_req_o && (reqc > waits);
      bus.mem_rdata_i = rd;
    end
    bus.mem_ready_i = 1'b0;
  endtask

  // Reference model state for the randomized phase
  logic [31:0] mem_m [0:63];
  int          free_at, tx_start, tx_len, tx_waits, m_streak, dcnt, waitc, reqc, dm_left, n;
  logic        tx_act, tx_dm, tx_we, tx_err;
  logic [31:0] tx_addr, tx_wd, tx_rd, exp_if_rd, exp_dm_rd;
  logic        e_req, e_ifa, e_dma, e_err;
  logic [31:0] a, wd;
  logic        we, ia, da, er, ifseen;
  logic [7:0]  seq;

  task automatic new_if();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'($urandom_range(0, 63)) << 2;
  endtask

  task automatic new_dm();
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'($urandom_range(0, 1));
    bus.dm_addr_i  = 32'($urandom_range(0, 63)) << 2;
    bus.dm_wdata_i = $urandom;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk1("rst_mem_req", bus.mem_req_o, 1'b0);
    chk1("rst_mem_we", bus.mem_we_o, 1'b0);
    chk1("rst_if_ack", bus.if_ack_o, 1'b0);
    chk1("rst_dm_ack", bus.dm_ack_o, 1'b0);
    chk1("rst_err", bus.err_o, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    chk32("rst_if_rdata", bus.if_rdata_o, 32'h0);
    chk32("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    rst = 1'b0;

    // Fetch with one wait cycle
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0010;
    #1 chk1("fetch_stall_wait", bus.stall_o, 1'b1);
    do_access(1, 32'h0010_0093, reqc, a, we, wd, ia, da, er);
    chk32("fetch_req_cycles", 32'(reqc), 32'd2);
    chk32("fetch_addr", a, 32'h10);
    chk1("fetch_we", we, 1'b0);
    chk1("fetch_if_ack", ia, 1'b1);
    chk1("fetch_dm_ack", da, 1'b0);
    chk32("fetch_rdata", bus.if_rdata_o, 32'h0010_0093);
    chk1("fetch_mem_req_low", bus.mem_req_o, 1'b0);
    chk1("fetch_stall_ack", bus.stall_o, 1'b0);
    bus.if_req_i = 1'b0;

    // Zero-wait store
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1;
    bus.dm_addr_i = 32'h40; bus.dm_wdata_i = 32'hDEAD_BEEF;
    do_access(0, 32'h1234_5678, reqc, a, we, wd, ia, da, er);
    chk32("store_req_cycles", 32'(reqc), 32'd1);
    chk32("store_addr", a, 32'h40);
    chk1("store_we", we, 1'b1);
    chk32("store_wdata", wd, 32'hDEAD_BEEF);
    chk1("store_dm_ack", da, 1'b1);
    chk1("store_err", er, 1'b0);
    chk32("store_dm_rdata", bus.dm_rdata_o, 32'h0);
    chk1("store_we_after", bus.mem_we_o, 1'b0);
    bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0;

    // Starvation bound: six data accesses against one waiting fetch
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    bus.dm_req_i = 1'b1; bus.dm_addr_i = 32'h44;
    dm_left = 6; n = 0; seq = '0;
    for (int c = 0; c < 80 && n < 7; c++) begin
      tick();
      if (bus.if_ack_o && bus.dm_ack_o) chk1("streak_dual_ack", 1'b1, 1'b0);
      if (bus.if_ack_o) begin
        seq[n] = 1'b1; n++; bus.if_req_i = 1'b0;
      end else if (bus.dm_ack_o) begin
        n++; dm_left--;
        if (dm_left == 0) bus.dm_req_i = 1'b0;
      end
      bus.mem_ready_i = bus.mem_req_o;
      bus.mem_rdata_i = 32'hA5A5_0000 | 32'(c);
    end
    bus.mem_ready_i = 1'b0;
    chk32("streak_grant_count", 32'(n), 32'd7);
    chk32("streak_order", {24'h0, seq}, 32'h0000_0010);

    // Timeout on a load
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h80;
    do_access(100, 32'h5555_5555, reqc, a, we, wd, ia, da, er);
    chk32("tmo_req_cycles", 32'(reqc), 32'd8);
    chk1("tmo_dm_ack", da, 1'b1);
    chk1("tmo_err", er, 1'b1);
    chk32("tmo_dm_rdata", bus.dm_rdata_o, 32'h0);
    bus.dm_req_i = 1'b0;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    do_access(0, 32'h0BAD_F00D, reqc, a, we, wd, ia, da, er);
    chk1("post_tmo_if_ack", ia, 1'b1);
    chk1("post_tmo_err", er, 1'b0);
    chk32("post_tmo_rdata", bus.if_rdata_o, 32'h0BAD_F00D);
    bus.if_req_i = 1'b0;

    // Reset during a data wait, with the streak at its limit
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h48;
    dcnt = 0; waitc = 0; ifseen = 1'b0;
    for (int c = 0; c < 60 && waitc < 2; c++) begin
      tick();
      if (bus.if_ack_o) ifseen = 1'b1;
      if (bus.dm_ack_o) dcnt++;
      bus.mem_ready_i = bus.mem_req_o && (dcnt < 3);
      if (bus.mem_req_o && dcnt >= 3) waitc++;
    end
    chk1("rstacc_no_fetch", ifseen, 1'b0);
    chk32("rstacc_wait", 32'(waitc), 32'd2);
    rst = 1'b1; bus.mem_ready_i = 1'b0;
    tick();
    rst = 1'b0;
    chk1("rstacc_mem_req", bus.mem_req_o, 1'b0);
    chk1("rstacc_dm_ack", bus.dm_ack_o, 1'b0);
    chk1("rstacc_err", bus.err_o, 1'b0);
    ia = 1'b0; da = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.if_ack_o || bus.dm_ack_o) begin
        ia = bus.if_ack_o; da = bus.dm_ack_o;
        break;
      end
      bus.mem_ready_i = bus.mem_req_o;
    end
    chk1("rstacc_first_dm", da, 1'b1);
    chk1("rstacc_first_not_if", ia, 1'b0);
    idle_inputs();

    // Randomized phase against the transaction-level model
    for (int i = 0; i < 64; i++) mem_m[i] = $urandom;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tx_act = 1'b0; free_at = 0; m_streak = 0; exp_if_rd = '0; exp_dm_rd = '0;
    tx_dm = 1'b0; tx_we = 1'b0; tx_err = 1'b0; tx_start = 0; tx_len = 0; tx_waits = 0;
    tx_addr = '0; tx_wd = '0; tx_rd = '0;
    for (int t = 0; t < 3000; t++) begin
      e_ifa = 1'b0; e_dma = 1'b0; e_err = 1'b0;
      if (tx_act && t == tx_start + tx_len) begin
        e_ifa = ~tx_dm; e_dma = tx_dm; e_err = tx_err;
        if (tx_dm) begin
          if (tx_err) exp_dm_rd = '0;
          else if (!tx_we) exp_dm_rd = tx_rd;
        end else begin
          exp_if_rd = tx_err ? 32'h0 : tx_rd;
        end
      end
      e_req = tx_act && t >= tx_start && t < tx_start + tx_len;
      chk1("rnd_mem_req", bus.mem_req_o, e_req);
      if (e_req) begin
        chk32("rnd_mem_addr", bus.mem_addr_o, tx_addr);
        chk1("rnd_mem_we", bus.mem_we_o, tx_we);
        if (tx_we) chk32("rnd_mem_wdata", bus.mem_wdata_o, tx_wd);
      end
      chk1("rnd_if_ack", bus.if_ack_o, e_ifa);
      chk1("rnd_dm_ack", bus.dm_ack_o, e_dma);
      chk1("rnd_err", bus.err_o, e_err);
      chk32("rnd_if_rdata", bus.if_rdata_o, exp_if_rd);
      chk32("rnd_dm_rdata", bus.dm_rdata_o, exp_dm_rd);
      if (e_ifa || e_dma) begin
        tx_act = 1'b0; free_at = t + 1;
      end

      if (e_req && !tx_err && t == tx_start + tx_waits) begin
        bus.mem_ready_i = 1'b1;
        if (tx_we) begin
          mem_m[tx_addr[7:2]] = tx_wd;
          bus.mem_rdata_i = $urandom;
        end else begin
          tx_rd = mem_m[tx_addr[7:2]];
          bus.mem_rdata_i = tx_rd;
        end
      end else begin
        bus.mem_ready_i = !e_req && ($urandom_range(0, 7) == 0);
        bus.mem_rdata_i = $urandom;
      end

      if (e_ifa) begin
        if ($urandom_range(0, 3) != 0) new_if(); else bus.if_req_i = 1'b0;
      end else if (!bus.if_req_i) begin
        if ($urandom_range(0, 2) == 0) new_if();
      end else if ($urandom_range(0, 39) == 0) begin
        bus.if_req_i = 1'b0;
      end
      if (e_dma) begin
        if ($urandom_range(0, 3) != 0) new_dm(); else bus.dm_req_i = 1'b0;
      end else if (!bus.dm_req_i) begin
        if ($urandom_range(0, 2) == 0) new_dm();
      end else if ($urandom_range(0, 39) == 0) begin
        bus.dm_req_i = 1'b0;
      end

      #1;
      chk1("rnd_stall", bus.stall_o,
           (bus.if_req_i & ~e_ifa) | (bus.dm_req_i & ~e_dma));

      // Grant taken at the edge closing an idle cycle
      if (!tx_act && t >= free_at && (bus.if_req_i || bus.dm_req_i)) begin
        tx_dm = bus.dm_req_i && !(bus.if_req_i && m_streak == MAXS);
        if (tx_dm && bus.if_req_i) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        else m_streak = 0;
        tx_act   = 1'b1;
        tx_start = t + 1;
        tx_addr  = tx_dm ? bus.dm_addr_i : bus.if_addr_i;
        tx_we    = tx_dm && bus.dm_we_i;
        tx_wd    = bus.dm_wdata_i;
        tx_waits = ($urandom_range(0, 9) == 0) ? 50 : int'($urandom_range(0, 3));
        tx_err   = (tx_waits >= TMO);
        tx_len   = tx_err ? TMO : tx_waits + 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
